mem_fetch_ctrl: RTL and testbench
=================================

# mem_fetch_ctrl

Bus initiator that reads bytes from the simple CPU's 6-bit-address, 8-bit-data read-only memory. Accepts a single-cycle request for a burst of 1–4 consecutive bytes and drives the memory's `addr`, `read` and active-low `ena` strobes. Captures each returned byte and presents it to the CPU datapath with a one-cycle valid pulse. Sits between the CPU fetch/load logic and the memory.

## Interface
- `WAIT_CYCLES`, default 1: cycles `read`/`ena` stay active per beat; must be ≥1.
- `DECODE_LIMIT`, default 4: first address not decoded by the memory; used only under the range-check option.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in 1: start a burst; sampled only in IDLE.
- `req_addr` in 6: first byte address.
- `req_len` in 2: beats minus one (0 = 1 byte, 3 = 4 bytes).
- `busy` out 1: high whenever the controller is not in IDLE.
- `rd_data` out 8: captured byte, held until the next capture.
- `rd_valid` out 1: one-cycle pulse per captured byte.
- `rd_err` out 1: one-cycle pulse alongside `rd_valid` for an out-of-range beat (range check only).
- `done` out 1: one-cycle pulse in the same cycle as the final `rd_valid`.
- `addr` out 6: memory address.
- `read` out 1: memory read strobe, active high.
- `ena` out 1: memory enable, active low.
- `data` in 8: memory data bus; ignored outside ACCESS.

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: `read`=0, `ena`=1. If `req`=1, latch `req_addr` into `addr` and `req_len` into the beat counter, then go to SETUP.
- SETUP: exactly 1 cycle with `addr` stable, `read`=0, `ena`=1. Then go to ACCESS.
- ACCESS: `read`=1, `ena`=0 for `WAIT_CYCLES` cycles. At the edge ending the last ACCESS cycle:
  - capture `data` into `rd_data` and assert `rd_valid` for the following cycle;
  - if beats remain, decrement the beat counter, set `addr` to `addr`+1 modulo 64 (63 wraps to 0), and go to SETUP;
  - otherwise go to IDLE and assert `done` with that `rd_valid`.
- Returning to SETUP between beats is mandatory. The memory only re-evaluates on a `read`/`ena` transition, so every beat must produce a fresh strobe edge.
- `req` while `busy` is ignored; no queueing. `req_addr` and `req_len` are don't-care outside the IDLE sampling edge.
- Reset, including mid-burst: immediately IDLE, `addr`=0, `read`=0, `ena`=1, `rd_data`=8'h00, `busy`/`rd_valid`/`rd_err`/`done`=0. A partial burst is discarded with no `done`.

## Timing
- `req` sampled at edge E0. SETUP occupies the cycle after E0. ACCESS occupies the next `WAIT_CYCLES` cycles.
- First `rd_valid` is high in the cycle after edge E(1+`WAIT_CYCLES`).
- Per-beat period is 1+`WAIT_CYCLES` cycles. A burst of N beats takes N·(1+`WAIT_CYCLES`) cycles from E0 to the last capture.
- `busy` drops in the same cycle `done` is high. A new `req` is accepted at the edge ending that cycle, giving back-to-back bursts with no idle gap.
- The wait counter width is wide enough to hold `WAIT_CYCLES`. The beat counter is 2 bits.

## Configuration
- `MEM_FETCH_RANGE_CHK_EN` defined: a beat whose `addr` ≥ `DECODE_LIMIT` skips ACCESS, so `read` never rises. At the edge ending SETUP, `rd_data` is set to 8'h00 and `rd_valid` and `rd_err` pulse together. Address increment and `done` behave as for normal beats. That beat's period is 1 cycle.
- `MEM_FETCH_RANGE_CHK_EN` undefined: every address is accessed normally, `rd_err` is tied to 0, and `DECODE_LIMIT` is unused.

## Structure
- Package `mem_fetch_pkg` holds the state enum, `ADDR_W`=6 and `DATA_W`=8.
- Single module with no sub-module. The wait counter and beat counter are small enough to inline.

## Test plan
All cases use a memory model holding F0/F1/F2/F3 at addresses 0–3 and Z elsewhere.
- Single read, `req_addr`=2, `req_len`=0, `WAIT_CYCLES`=1 -> `rd_data`=8'hF2, with `rd_valid` and `done` both high in the 3rd cycle after E0.
- Burst, `req_addr`=0, `req_len`=3 -> `rd_valid` every 2 cycles with F0, F1, F2, F3; `read` drops between every beat; `done` with F3.
- Wrap, `req_addr`=63, `req_len`=1 -> `addr` sequence 63 then 0.
  - With the option: `rd_err` on beat 1 with 8'h00, and `read` stays low for that beat; beat 2 returns F0.
  - Without the option: beat 2 returns F0.
- Mid-burst reset: `rst_n` low during ACCESS of beat 2 -> `read`=0, `ena`=1, `busy`=0 immediately, with no `done`. A following `req` to address 1 returns F1.
- `req` held high during a burst, then `WAIT_CYCLES`=3 with back-to-back requests -> extra `req` ignored; 4-cycle beat period; second burst's SETUP is in the cycle after `done`.

Source files
------------

// File: rtl/mem_fetch_pkg.sv
// Shared types and widths for the memory fetch controller.
// Used by mem_fetch_ctrl (range-check option: MEM_FETCH_RANGE_CHK_EN).
package mem_fetch_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_e;

endpackage

// File: rtl/mem_fetch_ctrl.sv
// Burst read initiator for the 6-bit/8-bit read-only memory.
// Option MEM_FETCH_RANGE_CHK_EN: beats at addr >= DECODE_LIMIT skip ACCESS.
module mem_fetch_ctrl
  import mem_fetch_pkg::*;
#(
  parameter int WAIT_CYCLES  = 1,
  parameter int DECODE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_len,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              read,
  output logic              ena,
  input  logic [DATA_W-1:0] data
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        beats_q, beats_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              beat_end;

`ifdef MEM_FETCH_RANGE_CHK_EN
  logic err_q, err_d;
  logic oor;
  assign oor = (int'(addr_q) >= DECODE_LIMIT);
`else
  localparam int unused_limit = DECODE_LIMIT;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    wcnt_d   = wcnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    beat_end = 1'b0;
`ifdef MEM_FETCH_RANGE_CHK_EN
    err_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          beats_d = req_len;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wcnt_d  = WW'(WAIT_CYCLES - 1);
        state_d = ST_ACCESS;
`ifdef MEM_FETCH_RANGE_CHK_EN
        if (oor) begin
          data_d   = '0;
          valid_d  = 1'b1;
          err_d    = 1'b1;
          beat_end = 1'b1;
        end
`endif
      end
      ST_ACCESS: begin
        if (wcnt_q == '0) begin
          data_d   = data;
          valid_d  = 1'b1;
          beat_end = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // every beat returns through SETUP so the memory sees a new strobe edge
    if (beat_end) begin
      if (beats_q != 2'd0) begin
        beats_d = beats_q - 2'd1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_SETUP;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef MEM_FETCH_RANGE_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign rd_err = err_q;
`else
  assign rd_err = 1'b0;
`endif

  assign busy     = (state_q != ST_IDLE);
  assign read     = (state_q == ST_ACCESS);
  assign ena      = ~read;
  assign addr     = addr_q;
  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
// Directed bench for mem_fetch_ctrl with scoreboarded read beats.
// Covers both builds of MEM_FETCH_RANGE_CHK_EN.
module tb_mem_fetch_ctrl;

  typedef struct packed {
    logic [9:0] exp;
    logic [9:0] mask;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sb_t qa[$];
  sb_t qb[$];

  logic       a_req = 1'b0, b_req = 1'b0;
  logic [5:0] a_raddr = '0, b_raddr = '0;
  logic [1:0] a_len = '0, b_len = '0;
  logic       a_busy, a_valid, a_err, a_done, a_read, a_ena;
  logic       b_busy, b_valid, b_err, b_done, b_read, b_ena;
  logic [7:0] a_data, b_data;
  logic [5:0] a_addr, b_addr;
  wire  [7:0] a_mdata, b_mdata;

  always #5 clk = ~clk;

  // memory: F0..F3 at 0..3, undriven elsewhere
  assign a_mdata = (!a_ena && a_read && a_addr < 6'd4) ?
                   {6'b111100, a_addr[1:0]} : 8'hzz;
  assign b_mdata = (!b_ena && b_read && b_addr < 6'd4) ?
                   {6'b111100, b_addr[1:0]} : 8'hzz;

  mem_fetch_ctrl #(.WAIT_CYCLES(1), .DECODE_LIMIT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .req_addr(a_raddr),
    .req_len(a_len), .busy(a_busy), .rd_data(a_data),
    .rd_valid(a_valid), .rd_err(a_err), .done(a_done),
    .addr(a_addr), .read(a_read), .ena(a_ena), .data(a_mdata)
  );

  mem_fetch_ctrl #(.WAIT_CYCLES(3), .DECODE_LIMIT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_addr(b_raddr),
    .req_len(b_len), .busy(b_busy), .rd_data(b_data),
    .rd_valid(b_valid), .rd_err(b_err), .done(b_done),
    .addr(b_addr), .read(b_read), .ena(b_ena), .data(b_mdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sb_t ent(input logic err, input logic dn,
                              input logic [7:0] d,
                              input logic [9:0] m);
    sb_t e;
    e.exp  = {err, dn, d};
    e.mask = m;
    return e;
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (a_done) chk("a_done_has_valid", 32'(a_valid), 1);
    if (a_valid) begin
      if (qa.size() == 0) chk("a_sb_unexpected", 0, 1);
      else begin
        e = qa.pop_front();
        chk("a_beat", 32'({a_err, a_done, a_data} & e.mask),
            32'(e.exp & e.mask));
      end
    end
    if (b_done) chk("b_done_has_valid", 32'(b_valid), 1);
    if (b_valid) begin
      if (qb.size() == 0) chk("b_sb_unexpected", 0, 1);
      else begin
        e = qb.pop_front();
        chk("b_beat", 32'({b_err, b_done, b_data} & e.mask),
            32'(e.exp & e.mask));
      end
    end
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_read", 32'(a_read), 0);
    chk("rst_ena", 32'(a_ena), 1);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_pulses", 32'({a_valid, a_err, a_done}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read at address 2
    a_req = 1'b1; a_raddr = 6'd2; a_len = 2'd0;
    qa.push_back(ent(1'b0, 1'b1, 8'hF2, 10'h3FF));
    @(negedge clk);
    a_req = 1'b0;
    chk("t1_setup_busy", 32'(a_busy), 1);
    chk("t1_setup_read", 32'(a_read), 0);
    chk("t1_setup_ena", 32'(a_ena), 1);
    chk("t1_setup_addr", 32'(a_addr), 2);
    @(negedge clk);
    chk("t1_acc_read", 32'(a_read), 1);
    chk("t1_acc_ena", 32'(a_ena), 0);
    @(negedge clk);
    chk("t1_valid", 32'(a_valid), 1);
    chk("t1_done", 32'(a_done), 1);
    chk("t1_busy", 32'(a_busy), 0);
    @(negedge clk);

    // 4-beat burst from 0 with req held high
    a_req = 1'b1; a_raddr = 6'd0; a_len = 2'd3;
    qa.push_back(ent(1'b0, 1'b0, 8'hF0, 10'h3FF));
    qa.push_back(ent(1'b0, 1'b0, 8'hF1, 10'h3FF));
    qa.push_back(ent(1'b0, 1'b0, 8'hF2, 10'h3FF));
    qa.push_back(ent(1'b0, 1'b1, 8'hF3, 10'h3FF));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) a_req = 1'b0;
      chk("t2_read", 32'(a_read), 32'(k % 2 == 0));
      chk("t2_ena", 32'(a_ena), 32'(k % 2 != 0));
      if (k % 2 == 1) chk("t2_addr", 32'(a_addr), 32'((k - 1) / 2));
    end
    @(negedge clk);
    chk("t2_done_busy", 32'(a_busy), 0);
    @(negedge clk);
    chk("t2_no_queue", 32'(a_busy), 0);

    // wrap 63 -> 0
    a_req = 1'b1; a_raddr = 6'd63; a_len = 2'd1;
`ifdef MEM_FETCH_RANGE_CHK_EN
    qa.push_back(ent(1'b1, 1'b0, 8'h00, 10'h3FF));
`else
    qa.push_back(ent(1'b0, 1'b0, 8'h00, 10'h300));
`endif
    qa.push_back(ent(1'b0, 1'b1, 8'hF0, 10'h3FF));
    @(negedge clk);
    a_req = 1'b0;
    chk("t3_addr63", 32'(a_addr), 63);
    @(negedge clk);
`ifdef MEM_FETCH_RANGE_CHK_EN
    chk("t3_no_read", 32'(a_read), 0);
    chk("t3_addr0", 32'(a_addr), 0);
`else
    chk("t3_read63", 32'(a_read), 1);
    @(negedge clk);
    chk("t3_addr0", 32'(a_addr), 0);
`endif
    repeat (3) @(negedge clk);
    chk("t3_idle", 32'(a_busy), 0);

    // reset during beat 2 ACCESS
    a_req = 1'b1; a_raddr = 6'd0; a_len = 2'd1;
    qa.push_back(ent(1'b0, 1'b0, 8'hF0, 10'h3FF));
    @(negedge clk);
    a_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_in_access", 32'(a_read), 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_read", 32'(a_read), 0);
    chk("t4_rst_ena", 32'(a_ena), 1);
    chk("t4_rst_busy", 32'(a_busy), 0);
    chk("t4_rst_done", 32'(a_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_req = 1'b1; a_raddr = 6'd1; a_len = 2'd0;
    qa.push_back(ent(1'b0, 1'b1, 8'hF1, 10'h3FF));
    @(negedge clk);
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_f1", 32'(a_data), 32'h0F1);

    // WAIT_CYCLES=3, req held, back-to-back bursts
    @(negedge clk);
    b_req = 1'b1; b_raddr = 6'd1; b_len = 2'd1;
    qb.push_back(ent(1'b0, 1'b0, 8'hF1, 10'h3FF));
    qb.push_back(ent(1'b0, 1'b1, 8'hF2, 10'h3FF));
    qb.push_back(ent(1'b0, 1'b1, 8'hF3, 10'h3FF));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b_raddr = 6'd3; b_len = 2'd0;
      end
      chk("t5_read", 32'(b_read), 32'(k % 4 != 1));
    end
    @(negedge clk);
    chk("t5_done", 32'(b_done), 1);
    chk("t5_done_busy", 32'(b_busy), 0);
    @(negedge clk);
    b_req = 1'b0;
    chk("t5_b2b_busy", 32'(b_busy), 1);
    chk("t5_b2b_addr", 32'(b_addr), 3);
    chk("t5_b2b_read", 32'(b_read), 0);
    repeat (4) @(negedge clk);
    chk("t5_done2", 32'(b_done), 1);
    @(negedge clk);
    chk("t5_idle", 32'(b_busy), 0);

    chk("sb_drain_a", 32'(qa.size()), 0);
    chk("sb_drain_b", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
